// File: rtl/player_input.sv
// rtl/player_input.sv - two-player button front end: synchronize, debounce, one-shot press pulses
// Each channel: 2-flop sync, streak-counter debounce, press pulse gated by enable at acceptance.
module player_input #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [1:0] raw_n;
  assign raw_n = {key_r_n, key_l_n};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic       s1;
    logic       s2;
    logic       pressed_sync;
    logic       stable;
    logic       pulse;
    logic [7:0] cnt;

    assign pressed_sync = ~s2;

    // Any matching cycle clears the streak, so bounces never accumulate.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1     <= 1'b1;
        s2     <= 1'b1;
        stable <= 1'b0;
        cnt    <= 8'd0;
        pulse  <= 1'b0;
      end else begin
        s1    <= raw_n[i];
        s2    <= s1;
        pulse <= 1'b0;
        if (pressed_sync == stable) begin
          cnt <= 8'd0;
        end else if (cnt == CNT_LAST) begin
          stable <= pressed_sync;
          cnt    <= 8'd0;
          pulse  <= enable & pressed_sync;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign L      = g_ch[0].pulse;
  assign R      = g_ch[1].pulse;
  assign held_l = g_ch[0].stable;
  assign held_r = g_ch[1].stable;

endmodule
